block_float_normalizer: RTL and testbench
=========================================

// Module: block_float_normalizer
// PURPOSE
//  Block-floating-point normaliser for signed sample streams. Buffers BLOCK_LEN
//  samples and finds the smallest headroom (redundant sign bits) across the block.
//  Then emits every sample left-shifted by that shared amount, with the shift as the
//  block exponent. Sits after the sample source, ahead of quantisation/packing stages.
// PARAMETERS
//  WIDTH      24         sample width, two's complement
//  BLOCK_LEN  16         samples per block (>=2)
//  MAX_SHIFT  WIDTH-1    cap on the shared shift (1..WIDTH-1)
// PORTS
//  clk        in   1                  clock, all logic rising-edge
//  rst        in   1                  synchronous reset, active-high
//  in_valid   in   1                  input sample valid
//  in_ready   out  1                  block can accept a sample
//  in_data    in   WIDTH              signed input sample
//  out_valid  out  1                  output sample valid
//  out_ready  in   1                  downstream accepts output
//  out_data   out  WIDTH              in_data <<< out_shift
//  out_shift  out  $clog2(WIDTH)      shared block exponent, constant within a block
//  out_last   out  1                  high with the final sample of a block
// BEHAVIOUR
//  Handshake: a transfer occurs on a cycle where valid&&ready. Once valid is high,
//   it and its data hold until the transfer. ready may depend on state only,
//   never combinationally on the same-cycle valid.
//  Reset: state=FILL, count=0, min_hr=MAX_SHIFT. Outputs after reset: in_ready=1,
//   out_valid=0, out_data=0, out_shift=0, out_last=0.
//  Headroom hr(x) = (number of leading bits equal to x[WIDTH-1]) - 1.
//   0 and -1 give WIDTH-1. -2^(WIDTH-1) and 2^(WIDTH-1)-1 give 0.
//   Computed combinationally per sample; min_hr = min(min_hr, min(hr, MAX_SHIFT)).
//  FILL: in_ready=1, out_valid=0. Each input transfer writes buffer[count], updates
//   min_hr and increments count. The transfer at count==BLOCK_LEN-1 latches
//   shift=min(min_hr, hr(x), MAX_SHIFT), sets rd=0 and enters DRAIN next cycle.
//  DRAIN: in_ready=0, out_valid=1, out_data=buffer[rd]<<<shift, out_shift=shift,
//   out_last=(rd==BLOCK_LEN-1).
//   Each output transfer increments rd. The transfer with out_last enters FILL next
//   cycle with count=0, min_hr=MAX_SHIFT and out_valid=0.
//   out_valid may stay high over any out_ready stall; outputs are stable while stalled.
//  Latency: first output is valid on the cycle after the last input transfer of a
//   block. Throughput is BLOCK_LEN in + BLOCK_LEN out cycles per block (no overlap).
//  Arithmetic: shift never exceeds the block minimum headroom, so the left shift
//   cannot overflow or flip sign. Output LSBs are zero-filled.
//  All-zero block: shift=MAX_SHIFT, all out_data=0. No separate flag; the consumer
//   detects zero blocks itself.
//  Counters: count and rd are $clog2(BLOCK_LEN)-bit plus terminal compare. They wrap
//   to 0 only via a block boundary and never free-run.
//  Simultaneous events: none possible; FILL and DRAIN are exclusive. in_valid during
//   DRAIN is ignored and must be held by the source.
//  rst mid-block (either state): buffered samples are discarded and the block is
//   restarted from FILL. No partial block is emitted.
// TESTING (WIDTH=24, BLOCK_LEN=4, MAX_SHIFT=23 unless noted)
//  1 Inputs 0x000100,0x000010,0xFFFF00,0x000000 -> out_shift=14 on all four.
//    out_data 0x400000,0x040000,0xC00000,0x000000; out_last only on the 4th.
//  2 Four samples of 0x000000 -> out_shift=23, out_data all 0.
//    Repeat with MAX_SHIFT=8 -> out_shift=8.
//  3 Block containing 0x800000 (and 0x7FFFFF in a second block) -> out_shift=0 and
//    data unchanged. Separately, all 0xFFFFFF -> out_shift=23, out_data=0x800000.
//  4 Hold out_ready=0 for 5 cycles mid-DRAIN -> out_valid, out_data and out_shift
//    stable. in_ready=0 throughout, and no sample is lost or duplicated.
//  5 Assert rst after 2 of 4 inputs -> next cycle in_ready=1, out_valid=0.
//    The next 4 inputs form a fresh block whose shift ignores the discarded samples.
//  6 Back-to-back random blocks with random valid/ready gaps, checked against a
//    scoreboard model -> every block exact, one out_last per block.

Source files
------------

// File: rtl/block_float_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : block_float_normalizer
// Description : Block-floating-point normaliser. Buffers BLOCK_LEN signed
//               samples, finds the smallest headroom in the block, then
//               replays every sample left-shifted by that shared exponent.
// Revision    : 1.0 - initial release
// ============================================================================
module block_float_normalizer #(
  parameter int WIDTH     = 24,
  parameter int BLOCK_LEN = 16,
  parameter int MAX_SHIFT = WIDTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(WIDTH)-1:0] out_shift,
  output logic                     out_last
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(BLOCK_LEN);
  localparam logic [SW-1:0] c_max_shift = SW'(MAX_SHIFT);
  localparam logic [CW-1:0] c_last_idx  = CW'(BLOCK_LEN - 1);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_rd;
  logic [SW-1:0]    r_min_hr;
  logic [SW-1:0]    r_shift;
  logic [WIDTH-1:0] r_buf [BLOCK_LEN];

  logic [SW-1:0]    w_hr;
  logic [SW-1:0]    w_hr_cap;
  logic [SW-1:0]    w_blk_min;
  logic             w_hr_stop;
  logic             w_in_fire;
  logic             w_out_fire;

  // Headroom of the incoming sample: run of bits below the MSB matching the sign.
  always_comb begin
    w_hr      = '0;
    w_hr_stop = 1'b0;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (!w_hr_stop && (in_data[i] == in_data[WIDTH-1])) begin
        w_hr = w_hr + 1'b1;
      end else begin
        w_hr_stop = 1'b1;
      end
    end
    w_hr_cap  = (w_hr > c_max_shift) ? c_max_shift : w_hr;
    w_blk_min = (w_hr_cap < r_min_hr) ? w_hr_cap : r_min_hr;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake/output decode; ready depends on state only.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_shift    = '0;
    out_last     = 1'b0;
    w_in_fire    = 1'b0;
    w_out_fire   = 1'b0;
    case (r_state)
      S_FILL: begin
        in_ready  = 1'b1;
        w_in_fire = in_valid;
        if (in_valid && (r_count == c_last_idx)) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_valid  = 1'b1;
        out_data   = r_buf[r_rd] << r_shift;
        out_shift  = r_shift;
        out_last   = (r_rd == c_last_idx);
        w_out_fire = out_ready;
        if (out_ready && (r_rd == c_last_idx)) begin
          w_next_state = S_FILL;
        end
      end
      default: begin
        w_next_state = S_FILL;
      end
    endcase
  end

  // Fill/drain counters, running block minimum and the latched block exponent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_rd     <= '0;
      r_min_hr <= c_max_shift;
      r_shift  <= '0;
    end else begin
      if (w_in_fire) begin
        if (r_count == c_last_idx) begin
          r_count  <= '0;
          r_rd     <= '0;
          r_shift  <= w_blk_min;
          r_min_hr <= c_max_shift;
        end else begin
          r_count  <= r_count + 1'b1;
          r_min_hr <= w_blk_min;
        end
      end
      if (w_out_fire) begin
        if (r_rd == c_last_idx) begin
          r_rd     <= '0;
          r_count  <= '0;
          r_min_hr <= c_max_shift;
        end else begin
          r_rd <= r_rd + 1'b1;
        end
      end
    end
  end

  // Sample buffer; contents are only meaningful up to the current fill count.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_buf[r_count] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_float_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_float_normalizer
// Description : Directed self-checking bench for block_float_normalizer
//               (WIDTH=24, BLOCK_LEN=4; second instance with MAX_SHIFT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_float_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [23:0] in_data, out_data;
  logic [4:0]  out_shift;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b;
  logic [23:0] in_data_b, out_data_b;
  logic [4:0]  out_shift_b;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  block_float_normalizer #(.WIDTH(24), .BLOCK_LEN(4), .MAX_SHIFT(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_shift(out_shift), .out_last(out_last)
  );

  block_float_normalizer #(.WIDTH(24), .BLOCK_LEN(4), .MAX_SHIFT(8)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_shift(out_shift_b), .out_last(out_last_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one sample; returns at the negedge after it has been accepted.
  task automatic send(input logic [23:0] x, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    t = 0;
    while (!in_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Accept one output sample and check it; returns at the negedge after transfer.
  task automatic recv(input string tag, input logic [23:0] d, input logic [4:0] s,
                      input logic l, input int gap);
    int t;
    out_ready = 1'b0;
    repeat (gap) @(negedge clk);
    out_ready = 1'b1;
    t = 0;
    while (!out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"},  {8'd0, out_data},   {8'd0, d});
    chk({tag, "_shift"}, {27'd0, out_shift}, {27'd0, s});
    chk({tag, "_last"},  {31'd0, out_last},  {31'd0, l});
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic int model_hr(input logic [23:0] x);
    int n = 0;
    for (int i = 22; i >= 0; i--) begin
      if (x[i] !== x[23]) break;
      n++;
    end
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] blk [4];
    int          sh;
    logic [23:0] r;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {8'd0, out_data},   32'd0);
    chk("rst_out_shift", {27'd0, out_shift}, 32'd0);
    chk("rst_out_last",  {31'd0, out_last},  32'd0);

    // Test 1: mixed block, minimum headroom 14
    send(24'h000100, 0); send(24'h000010, 0); send(24'hFFFF00, 0); send(24'h000000, 0);
    chk("t1_latency_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_in_ready_low",  {31'd0, in_ready},  32'd0);
    recv("t1_0", 24'h400000, 5'd14, 1'b0, 0);
    recv("t1_1", 24'h040000, 5'd14, 1'b0, 0);
    recv("t1_2", 24'hC00000, 5'd14, 1'b0, 0);
    recv("t1_3", 24'h000000, 5'd14, 1'b1, 0);
    chk("t1_back_to_fill", {31'd0, out_valid}, 32'd0);

    // Test 2: all-zero block, full cap and reduced cap
    repeat (4) send(24'h000000, 0);
    for (int k = 0; k < 4; k++) recv("t2_zero", 24'h000000, 5'd23, k == 3, 0);
    in_valid_b = 1'b1; in_data_b = 24'h000000;
    repeat (4) @(negedge clk);
    in_valid_b = 1'b0;
    chk("t2b_valid", {31'd0, out_valid_b}, 32'd1);
    chk("t2b_shift", {27'd0, out_shift_b}, 32'd8);
    chk("t2b_data",  {8'd0, out_data_b},   32'd0);
    out_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("t2b_last", {31'd0, out_last_b}, 32'd1);
    @(negedge clk);
    out_ready_b = 1'b0;
    chk("t2b_done", {31'd0, out_valid_b}, 32'd0);

    // Test 3: full-scale values give shift 0; all -1 gives shift 23
    send(24'h800000, 0); send(24'h000001, 0); send(24'h000002, 0); send(24'h000003, 0);
    recv("t3a_0", 24'h800000, 5'd0, 1'b0, 0);
    recv("t3a_1", 24'h000001, 5'd0, 1'b0, 0);
    recv("t3a_2", 24'h000002, 5'd0, 1'b0, 0);
    recv("t3a_3", 24'h000003, 5'd0, 1'b1, 0);
    send(24'h7FFFFF, 0); send(24'h000000, 0); send(24'h000000, 0); send(24'h000000, 0);
    recv("t3b_0", 24'h7FFFFF, 5'd0, 1'b0, 0);
    for (int k = 1; k < 4; k++) recv("t3b_k", 24'h000000, 5'd0, k == 3, 0);
    repeat (4) send(24'hFFFFFF, 0);
    for (int k = 0; k < 4; k++) recv("t3c", 24'h800000, 5'd23, k == 3, 0);

    // Test 4: stall mid-drain while a source holds the next sample
    send(24'h000003, 0); send(24'hFFFFFC, 0); send(24'h000001, 0); send(24'h000007, 0);
    recv("t4_0", 24'h300000, 5'd20, 1'b0, 0);
    recv("t4_1", 24'hC00000, 5'd20, 1'b0, 0);
    in_valid = 1'b1; in_data = 24'h000123;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_stall_data",  {8'd0, out_data},   32'h100000);
      chk("t4_stall_shift", {27'd0, out_shift}, 32'd20);
      chk("t4_stall_inrdy", {31'd0, in_ready},  32'd0);
    end
    recv("t4_2", 24'h100000, 5'd20, 1'b0, 0);
    recv("t4_3", 24'h700000, 5'd20, 1'b1, 0);
    send(24'h000123, 0); send(24'h000010, 0); send(24'h000020, 0); send(24'h000040, 0);
    recv("t4n_0", 24'h48C000, 5'd14, 1'b0, 0);
    recv("t4n_1", 24'h040000, 5'd14, 1'b0, 0);
    recv("t4n_2", 24'h080000, 5'd14, 1'b0, 0);
    recv("t4n_3", 24'h100000, 5'd14, 1'b1, 0);

    // Test 5: reset after two samples discards them
    send(24'h400000, 0); send(24'h000001, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_in_ready",  {31'd0, in_ready},  32'd1);
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (4) send(24'h000100, 0);
    for (int k = 0; k < 4; k++) recv("t5", 24'h400000, 5'd14, k == 3, 0);

    // Test 6: random blocks with random gaps against a model
    for (int b = 0; b < 4; b++) begin
      sh = 23;
      for (int k = 0; k < 4; k++) begin
        r = 24'($urandom);
        blk[k] = 24'($signed(r) >>> $urandom_range(0, 23));
        if (model_hr(blk[k]) < sh) sh = model_hr(blk[k]);
      end
      for (int k = 0; k < 4; k++) send(blk[k], $urandom_range(0, 3));
      for (int k = 0; k < 4; k++)
        recv("t6", 24'(blk[k] << sh), 5'(sh), k == 3, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
